fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end for the pipelined RV32I core.
- Replaces the direct PC/instruction-memory path that feeds the decode pipeline register.
- Owns the fetch PC and issues word requests over a variable-latency req/ack instruction-memory port.
- Buffers returned instructions with their PCs in a small FIFO; decode consumes them with a valid/ready handshake. The execute stage redirects fetch on taken branches and jumps.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch address after reset; word-aligned

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
redirect_en  input  1  taken branch/jump from execute (pc_srcE)
redirect_pc  input  32  redirect target (pc_targetE)
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  request word address
imem_ack  input  1  response valid; imem_rdata valid this cycle
imem_rdata  input  32  returned instruction
instr_valid  output  1  head entry valid
instr_ready  input  1  decode accepts head (~stallD)
instrF  output  32  head instruction
pcF  output  32  head PC
pc_plus_4F  output  32  pcF + 4

Behaviour:
- Reset: at the clock edge where reset is high, all state is cleared.
  - fetch_pc = RESET_PC; FIFO empty (count = 0, pointers 0); no request outstanding; kill flag clear.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instrF = 32'h0000_0013 (NOP), pcF = 0.
- Reset mid-transaction abandons any in-flight request; a later imem_ack for it is ignored.
- imem_req and imem_addr are registered outputs. At most one request is outstanding.
- Issue rule: a request is issued when no request is outstanding, not reset, and (count + pushes pending) < DEPTH.
  - Issuing means imem_req = 1 and imem_addr = fetch_pc on the next cycle.
- Once raised, imem_req and imem_addr are held stable until the cycle in which imem_ack = 1.
  - A request is never withdrawn, including across a redirect.
- On an ack:
  - Unkilled request: {imem_rdata, imem_addr} is pushed and fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - The next request may be asserted in the cycle right after the ack, giving 1 instr/cycle with single-cycle-ack memory.
- FIFO is show-ahead.
  - instr_valid = (count != 0); instrF, pcF and the head PC are driven combinationally from the head entry.
  - pc_plus_4F = pcF + 4, combinational, 32-bit wrap.
  - When empty: instrF = NOP, pcF = 0.
- Pop occurs when instr_valid & instr_ready.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Redirect has priority over push and pop. In a cycle with redirect_en = 1:
  - At the edge, the FIFO is cleared and fetch_pc = {redirect_pc[31:2], 2'b00} (low bits forced to 0).
  - A same-cycle pop or ack push is discarded.
  - If a request is outstanding and not acked this cycle, the kill flag is set.
- Kill flag:
  - The killed request stays asserted with its old address until ack; its data is dropped, fetch_pc does not advance, and the flag clears.
  - The first request to the redirect target is issued the cycle after that ack.
- A second redirect while a kill is pending overwrites fetch_pc; only one kill flag is needed.
- instr_valid never shows a wrong-path entry in the cycle after a redirect.

Test Plan:
- Reset with RESET_PC=0, single-cycle ack, instr_ready=1 -> imem_addr sequence 0,4,8,C; instr_valid rises the cycle after the first ack; pcF 0,4,8 on consecutive cycles; pc_plus_4F = pcF+4.
- instr_ready=0 with single-cycle ack -> four pushes, count=4, imem_req=0 held; one pop -> next request addr 0x10 issued.
- Ack latency 3, redirect_pc=0x100 while addr 0x8 is outstanding -> imem_addr stays 0x8 until ack; that data is dropped; next imem_addr=0x100; instr_valid=0 until 0x100 data is pushed.
- Redirect, ack and pop in the same cycle with 2 entries queued -> next cycle instr_valid=0, count=0; ack data is absent; next request addr = redirect target.
- Redirect to 0x103 -> fetch 0x100. RESET_PC=32'hFFFF_FFFC -> first pcF=FFFF_FFFC, pc_plus_4F=0, next imem_addr=0.
- Reset asserted while imem_req=1 awaiting ack -> next cycle imem_req=0, instr_valid=0; a stale ack arriving after reset pushes nothing; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: owns the fetch PC, issues one word request at a time
// over a req/ack memory port and buffers returned {instr, pc} pairs in a show-ahead FIFO.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instrF,
   output logic [31:0] pcF,
   output logic [31:0] pc_plus_4F
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   instrMem [DEPTH];
   logic [31:0]   pcMem    [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic [CW-1:0] countNext;
   logic [31:0]   fetchPc;
   logic [31:0]   fetchPcNext;
   logic          killPending;

   logic ackSeen;
   logic stillOutstanding;
   logic doPush;
   logic doPop;
   logic issue;

   // Memory side: imem_req/imem_addr stay stable from the cycle they rise until the cycle with
   // imem_ack high, which completes the transfer. Decode side: the head moves when instr_valid & instr_ready.
   assign ackSeen          = imem_req & imem_ack;
   assign stillOutstanding = imem_req & ~imem_ack;
   assign doPush           = ackSeen & ~killPending & ~redirect_en;
   assign doPop            = instr_valid & instr_ready & ~redirect_en;

   assign instr_valid = (count != '0);
   assign instrF      = instr_valid ? instrMem[rdPtr] : NOP;
   assign pcF         = instr_valid ? pcMem[rdPtr] : 32'h0000_0000;
   assign pc_plus_4F  = pcF + 32'd4;

   always_comb begin
      countNext = count;
      if (redirect_en) begin
         countNext = '0;
      end else if (doPush && !doPop) begin
         countNext = count + CW'(1);
      end else if (!doPush && doPop) begin
         countNext = count - CW'(1);
      end
   end

   always_comb begin
      fetchPcNext = fetchPc;
      if (redirect_en) begin
         fetchPcNext = {redirect_pc[31:2], 2'b00};
      end else if (doPush) begin
         fetchPcNext = fetchPc + 32'd4;
      end
   end

   // Looking at the post-edge occupancy lets a new request follow an ack back to back.
   assign issue = ~stillOutstanding & (countNext < CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (doPush) begin
         instrMem[wrPtr] <= imem_rdata;
         pcMem[wrPtr]    <= imem_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetchPc     <= RESET_PC;
         count       <= '0;
         rdPtr       <= '0;
         wrPtr       <= '0;
         killPending <= 1'b0;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
      end else begin
         fetchPc <= fetchPcNext;
         count   <= countNext;
         if (redirect_en) begin
            rdPtr <= '0;
            wrPtr <= '0;
         end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
         end
         // A request caught by a redirect is never withdrawn; its data is dropped on ack instead.
         if (redirect_en && stillOutstanding) begin
            killPending <= 1'b1;
         end else if (ackSeen) begin
            killPending <= 1'b0;
         end
         imem_req <= stillOutstanding | issue;
         if (issue) imem_addr <= fetchPcNext;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run, all checked against a
// transaction-level model (expected FIFO contents, fetch PC, outstanding request, kill flag).
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
   logic [31:0] instrF;
   logic [31:0] pcF;
   logic [31:0] pc_plus_4F;
   logic        wImemReq;
   logic [31:0] wImemAddr;
   logic        wInstrValid;
   logic [31:0] wInstrF;
   logic [31:0] wPcF;
   logic [31:0] wPcPlus4F;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instrF(instrF), .pcF(pcF),
      .pc_plus_4F(pc_plus_4F)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(wImemReq), .imem_addr(wImemAddr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(wInstrValid), .instr_ready(instr_ready), .instrF(wInstrF), .pcF(wPcF),
      .pc_plus_4F(wPcPlus4F)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] exp_q[$];
   logic [31:0] mFetchPc;
   logic        mReq;
   logic [31:0] mAddr;
   logic        mKill;
   int          reqAge;
   int          ackLat;
   int          checks;
   int          errors;

   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h0000_0013;
   endfunction

   // Advance one clock; the model consumes the inputs as they stand before the edge.
   task automatic tick();
      logic acked;
      logic prevReq;
      acked   = mReq && imem_ack;
      prevReq = mReq;
      if (reset) begin
         exp_q.delete();
         mFetchPc = 32'h0;
         mReq     = 1'b0;
         mAddr    = 32'h0;
         mKill    = 1'b0;
      end else begin
         if (redirect_en) begin
            exp_q.delete();
            mFetchPc = {redirect_pc[31:2], 2'b00};
            if (mReq && !imem_ack) mKill = 1'b1;
            else if (acked)        mKill = 1'b0;
         end else begin
            if (exp_q.size() != 0 && instr_ready) void'(exp_q.pop_front());
            if (acked) begin
               if (mKill) mKill = 1'b0;
               else begin
                  exp_q.push_back({mAddr, imem_rdata});
                  mFetchPc = mFetchPc + 32'd4;
               end
            end
         end
         if (acked) mReq = 1'b0;
         if (!mReq && exp_q.size() < DEPTH) begin
            mReq  = 1'b1;
            mAddr = mFetchPc;
         end
      end
      @(posedge clk);
      #1;
      reqAge = (mReq && prevReq && !acked) ? reqAge + 1 : 0;
   endtask

   // Memory responder: acks after ackLat extra cycles of the request being visible.
   task automatic driveAck();
      imem_ack   = mReq && (reqAge >= ackLat);
      imem_rdata = instrOf(mAddr);
   endtask

   task automatic doReset();
      reset = 1'b1; redirect_en = 1'b0; imem_ack = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
      checks++; if (instrF !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", instrF); end
      checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pcF); end
      reset = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL first_issue: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      doReset();
      instr_ready = 1'b1; ackLat = 0;
      for (int i = 0; i < 4; i++) begin
         driveAck(); tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i + 1))) begin
            errors++; $display("FAIL stream_addr[%0d]: got req=%0b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * (i + 1)));
         end
         checks++; if (instr_valid !== 1'b1 || pcF !== 32'(4 * i) || pc_plus_4F !== 32'(4 * i + 4)) begin
            errors++; $display("FAIL stream_head[%0d]: got v=%0b pc=%h pc4=%h want v=1 pc=%h pc4=%h", i, instr_valid, pcF, pc_plus_4F, 32'(4 * i), 32'(4 * i + 4));
         end
         checks++; if (instrF !== instrOf(32'(4 * i))) begin
            errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instrF, instrOf(32'(4 * i)));
         end
      end
   endtask

   task automatic test_backpressure();
      doReset();
      instr_ready = 1'b0; ackLat = 0;
      repeat (6) begin driveAck(); tick(); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %0b want 0", imem_req); end
      checks++; if (instr_valid !== 1'b1 || pcF !== 32'h0) begin
         errors++; $display("FAIL full_head: got v=%0b pc=%h want v=1 pc=0", instr_valid, pcF);
      end
      instr_ready = 1'b1; driveAck(); tick();
      instr_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
         errors++; $display("FAIL refill_req: got req=%0b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
      end
      checks++; if (pcF !== 32'h4) begin errors++; $display("FAIL refill_head: got %h want 00000004", pcF); end
   endtask

   task automatic test_kill();
      bit found;
      doReset();
      instr_ready = 1'b1; ackLat = 2; found = 0;
      for (int k = 0; k < 30; k++) begin
         if (mReq && mAddr == 32'h8 && reqAge == 0) begin found = 1; break; end
         driveAck(); tick();
      end
      checks++; if (!found || imem_addr !== 32'h8) begin
         errors++; $display("FAIL kill_setup: got addr=%h want 00000008 (reached=%0b)", imem_addr, found);
      end
      redirect_en = 1'b1; redirect_pc = 32'h100; driveAck(); tick();
      redirect_en = 1'b0;
      found = 0;
      for (int k = 0; k < 10; k++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL kill_hold: got req=%0b addr=%h v=%0b want req=1 addr=00000008 v=0", imem_req, imem_addr, instr_valid);
         end
         driveAck(); tick();
         if (mAddr != 32'h8) begin found = 1; break; end
      end
      checks++; if (!found || imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL kill_target: got req=%0b addr=%h v=%0b want req=1 addr=00000100 v=0", imem_req, imem_addr, instr_valid);
      end
      found = 0;
      for (int k = 0; k < 10; k++) begin
         driveAck(); tick();
         if (exp_q.size() != 0) begin found = 1; break; end
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL kill_empty: got v=%0b want 0", instr_valid); end
      end
      checks++; if (!found || instr_valid !== 1'b1 || pcF !== 32'h100 || instrF !== instrOf(32'h100)) begin
         errors++; $display("FAIL kill_first: got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=%h", instr_valid, pcF, instrF, instrOf(32'h100));
      end
   endtask

   task automatic test_same_cycle();
      doReset();
      instr_ready = 1'b0; ackLat = 0;
      driveAck(); tick(); driveAck(); tick();
      checks++; if (instr_valid !== 1'b1 || pcF !== 32'h0 || imem_addr !== 32'h8) begin
         errors++; $display("FAIL same_setup: got v=%0b pc=%h addr=%h want v=1 pc=0 addr=00000008", instr_valid, pcF, imem_addr);
      end
      redirect_en = 1'b1; redirect_pc = 32'h203; instr_ready = 1'b1; driveAck(); tick();
      redirect_en = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++; $display("FAIL same_redirect: got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000200", instr_valid, imem_req, imem_addr);
      end
      driveAck(); tick();
      checks++; if (instr_valid !== 1'b1 || pcF !== 32'h200 || pc_plus_4F !== 32'h204) begin
         errors++; $display("FAIL same_target: got v=%0b pc=%h pc4=%h want v=1 pc=00000200 pc4=00000204", instr_valid, pcF, pc_plus_4F);
      end
   endtask

   task automatic test_wrap();
      doReset();
      instr_ready = 1'b0; ackLat = 0;
      checks++; if (wImemReq !== 1'b1 || wImemAddr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_issue: got req=%0b addr=%h want req=1 addr=fffffffc", wImemReq, wImemAddr);
      end
      driveAck(); tick();
      checks++; if (wInstrValid !== 1'b1 || wPcF !== 32'hFFFF_FFFC || wPcPlus4F !== 32'h0) begin
         errors++; $display("FAIL wrap_head: got v=%0b pc=%h pc4=%h want v=1 pc=fffffffc pc4=0", wInstrValid, wPcF, wPcPlus4F);
      end
      checks++; if (wImemReq !== 1'b1 || wImemAddr !== 32'h0 || wInstrF !== instrOf(32'h0)) begin
         errors++; $display("FAIL wrap_next: got req=%0b addr=%h instr=%h want req=1 addr=0 instr=%h", wImemReq, wImemAddr, wInstrF, instrOf(32'h0));
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      instr_ready = 1'b1; ackLat = 3;
      driveAck(); tick();
      reset = 1'b1; imem_ack = 1'b0; tick();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL midreset: got req=%0b v=%0b addr=%h want req=0 v=0 addr=0", imem_req, instr_valid, imem_addr);
      end
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL stale_ack: got req=%0b addr=%h v=%0b want req=1 addr=0 v=0", imem_req, imem_addr, instr_valid);
      end
      ackLat = 0; driveAck(); tick();
      checks++; if (instr_valid !== 1'b1 || pcF !== 32'h0 || instrF !== instrOf(32'h0)) begin
         errors++; $display("FAIL restart: got v=%0b pc=%h instr=%h want v=1 pc=0 instr=%h", instr_valid, pcF, instrF, instrOf(32'h0));
      end
   endtask

   task automatic test_random();
      logic [63:0] head;
      doReset();
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         redirect_en = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         instr_ready = $urandom_range(0, 1) == 1;
         imem_ack    = $urandom_range(0, 2) != 0;
         imem_rdata  = mReq ? instrOf(mAddr) : $urandom;
         tick();
         head = (exp_q.size() != 0) ? exp_q[0] : {32'h0, 32'h0000_0013};
         checks++; if (imem_req !== mReq || (mReq && imem_addr !== mAddr)) begin
            errors++; $display("FAIL rand_req[%0d]: got req=%0b addr=%h want req=%0b addr=%h", n, imem_req, imem_addr, mReq, mAddr);
         end
         checks++; if (instr_valid !== (exp_q.size() != 0) || pcF !== head[63:32] || instrF !== head[31:0]) begin
            errors++; $display("FAIL rand_head[%0d]: got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h", n, instr_valid, pcF, instrF, exp_q.size() != 0, head[63:32], head[31:0]);
         end
         checks++; if (pc_plus_4F !== head[63:32] + 32'd4) begin
            errors++; $display("FAIL rand_pc4[%0d]: got %h want %h", n, pc_plus_4F, head[63:32] + 32'd4);
         end
      end
      reset = 1'b0; redirect_en = 1'b0; imem_ack = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; reqAge = 0; ackLat = 0;
      mFetchPc = 32'h0; mReq = 1'b0; mAddr = 32'h0; mKill = 1'b0;
      reset = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_kill();
      test_same_cycle();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
